dec_trigger_seq: RTL and testbench
==================================

DEC_TRIGGER_SEQ -- requirements
Module: dec_trigger_seq

Interface
REQ-001 SHALL have parameter NUM_TRIG, default 4, number of triggers (1..8).
REQ-002 SHALL have parameter NUM_LANES, default 2, decode lanes; lane 0 is oldest.
REQ-003 SHALL have parameter CNT_W, default 8, hit-counter width.
REQ-004 Port clk  input  1  sole clock.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port trig_cfg  input  NUM_TRIG x trig_cfg_t  per-trigger select, execute, m, match, chain, tdata2[31:0], hit_lim[CNT_W-1:0].
REQ-007 Port cfg_wr_en  input  NUM_TRIG  pulse: trigger CSR rewritten this cycle.
REQ-008 Port lane_valid  input  NUM_LANES  lane holds a valid instruction.
REQ-009 Port lane_pc  input  NUM_LANES x 31  lane PC[31:1].
REQ-010 Port dec_flush  input  1  pipeline flush.
REQ-011 Port lane_trigger_match  output  NUM_LANES x NUM_TRIG  registered fire vector.
REQ-012 Port trig_armed  output  NUM_TRIG  chain-arm state, for debug CSR readback.

Function
REQ-013 Raw match[l][i] SHALL = lane_valid[l] & execute & ~select & m & maskandmatch(tdata2, {lane_pc[l], tdata2[0]}, match); match=1 means masked compare, 0 means full compare.
REQ-014 Trigger i SHALL be gated when i>0 and trig_cfg[i-1].chain=1; gated triggers are eligible only while armed[i]=1 (registered value).
REQ-015 Trigger i with chain=1 and i<NUM_TRIG-1 SHALL never fire itself; any lane raw match sets armed[i+1] next cycle. chain on the last trigger SHALL be ignored.
REQ-016 Arming SHALL take effect the cycle after the arming match; a same-cycle match of the gated trigger on any lane SHALL NOT fire.
REQ-017 A fire of a gated trigger SHALL clear its armed bit next cycle; a simultaneous arm-and-fire SHALL leave armed=1.
REQ-018 Eligible cycle for trigger i = at least one lane with raw match and eligibility; counter increments by 1 per eligible cycle, not per lane.
REQ-019 hit_lim=0 SHALL fire on every eligible cycle; otherwise fire when cnt_q+1 >= hit_lim; counter saturates at 2^CNT_W-1, no wrap.
REQ-020 On a fire, every eligible matching lane bit SHALL be set; latency exactly 1 cycle from lane_pc to lane_trigger_match.
REQ-021 cfg_wr_en[i] SHALL clear cnt[i], armed[i] and armed[i+1], suppress trigger i output next cycle, and take priority over same-cycle updates.
REQ-022 dec_flush SHALL clear all armed bits, force lane_trigger_match to 0 next cycle, and inhibit counter updates that cycle.

Reset
REQ-023 rst SHALL clear lane_trigger_match, trig_armed and all counters to 0 at the next clk edge; reset mid-chain discards arming.

Configuration
REQ-024 With RV_TRIGGER_HITCNT_EN defined, hit counters SHALL exist per REQ-019. Without it, no counter flops SHALL be built, hit_lim SHALL be ignored, and every eligible cycle SHALL fire.

Structure
REQ-025 trig_cfg_t SHALL be defined in swerv_types_pkg beside trigger_pkt_t; CNT_W default SHALL be a package constant.
REQ-026 Per-lane/per-trigger comparison SHALL be one sub-module, dec_trig_cmp, wrapping rvmaskandmatch and the REQ-013 qualifiers.

Verification
REQ-027 T0 tdata2=0x8000_1000, match=0, lane0 pc=0x8000_1000 valid -> lane_trigger_match[0][0]=1 exactly one cycle later, lane1 bit 0.
REQ-028 T0 match=1, tdata2=0x8000_10FF (low-ones mask, 256-byte window), lane1 pc=0x8000_1044 -> [1][0]=1; pc=0x8000_1100 -> 0.
REQ-029 T0 chain=1 @0x100, T1 @0x200: 0x100 then 0x200 next cycle -> only T1 fires, trig_armed[1] 1 then 0; both in same cycle on lanes 0/1 -> no fire.
REQ-030 hit_lim=3, PC matches on both lanes for 4 cycles -> fires cycles 3 and 4 only, cnt saturates; with macro undefined -> fires all 4 cycles.
REQ-031 T1 armed, dec_flush=1 -> trig_armed=0, outputs 0 next cycle; cfg_wr_en[0] during chain -> armed[1] cleared.
REQ-032 rst asserted while armed and cnt=2 -> all outputs and state 0 after one clk edge.

Source files
------------

// File: rtl/swerv_types_pkg.sv
// Shared decode/trigger types.
//   trigger_pkt_t : legacy per-trigger packet consumed by the decode stage.
//   trig_cfg_t    : per-trigger configuration for dec_trigger_seq.
//   TRIG_CNT_W    : default hit-counter width.
//   rvmaskandmatch: NAPOT-style address compare. With masken set, every
//                   trailing-ones bit of mask (and only those) is a don't-care.
package swerv_types_pkg;

  localparam int unsigned TRIG_CNT_W = 8;

  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } trigger_pkt_t;

  typedef struct packed {
    logic                  select;
    logic                  execute;
    logic                  m;
    logic                  match;
    logic                  chain;
    logic [31:0]           tdata2;
    logic [TRIG_CNT_W-1:0] hit_lim;
  } trig_cfg_t;

  function automatic logic rvmaskandmatch(input logic [31:0] mask,
                                          input logic [31:0] data,
                                          input logic        masken);
    logic ones;
    logic ok;
    ones = 1'b1;
    ok   = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      ones = ones & mask[i];
      if (!((masken && ones) || (mask[i] == data[i]))) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dec_trigger_seq_if.sv
// Trigger-sequencer bus between decode (master) and dec_trigger_seq (slave).
//   trig_cfg           : per-trigger configuration
//   cfg_wr_en          : per-trigger CSR write pulse
//   lane_valid/lane_pc : decode lanes, lane 0 oldest, PC[31:1]
//   dec_flush          : pipeline flush
//   lane_trigger_match : registered fire vector [lane][trigger]
//   trig_armed         : chain-arm state
interface dec_trigger_seq_if
  import swerv_types_pkg::*;
#(
  parameter int unsigned NUM_TRIG  = 4,
  parameter int unsigned NUM_LANES = 2
);
  trig_cfg_t [NUM_TRIG-1:0]               trig_cfg;
  logic      [NUM_TRIG-1:0]               cfg_wr_en;
  logic      [NUM_LANES-1:0]              lane_valid;
  logic      [NUM_LANES-1:0][30:0]        lane_pc;
  logic                                   dec_flush;
  logic      [NUM_LANES-1:0][NUM_TRIG-1:0] lane_trigger_match;
  logic      [NUM_TRIG-1:0]               trig_armed;

  modport master (
    output trig_cfg, cfg_wr_en, lane_valid, lane_pc, dec_flush,
    input  lane_trigger_match, trig_armed
  );

  modport slave (
    input  trig_cfg, cfg_wr_en, lane_valid, lane_pc, dec_flush,
    output lane_trigger_match, trig_armed
  );
endinterface

// File: rtl/dec_trig_cmp.sv
// Raw match of one decode lane against one trigger.
//   valid, pc[30:0]           : lane valid / PC[31:1]
//   select, execute, m, match : trigger qualifiers (match=1 -> masked compare)
//   tdata2                    : compare value / mask
//   hit                       : raw match (no chaining or hit counting)
module dec_trig_cmp
  import swerv_types_pkg::*;
(
  input  logic        valid,
  input  logic [30:0] pc,
  input  logic        select,
  input  logic        execute,
  input  logic        m,
  input  logic        match,
  input  logic [31:0] tdata2,
  output logic        hit
);
  // Bit 0 of the compare value comes from tdata2 so it never causes a miss.
  assign hit = valid & execute & ~select & m &
               rvmaskandmatch(tdata2, {pc, tdata2[0]}, match);
endmodule

// File: rtl/dec_trigger_seq.sv
// Decode-stage instruction-address trigger sequencer with chaining and
// optional hit counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dec_trigger_seq_if.slave (config, lanes, flush, fire vector, arm state)
// Build option: RV_TRIGGER_HITCNT_EN adds per-trigger hit counters honouring
// hit_lim; without it every eligible cycle fires and hit_lim is ignored.
module dec_trigger_seq
  import swerv_types_pkg::*;
#(
  parameter int unsigned NUM_TRIG  = 4,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned CNT_W     = TRIG_CNT_W
) (
  input logic              clk,
  input logic              rst,
  dec_trigger_seq_if.slave bus
);

  logic [NUM_LANES-1:0][NUM_TRIG-1:0] raw, elig, match_d, match_q;
  logic [NUM_TRIG-1:0] gated, chainer, elig_any, fire, fire_ok, arm_src;
  logic [NUM_TRIG-1:0] armed_d, armed_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar t = 0; t < NUM_TRIG; t++) begin : g_trig
      dec_trig_cmp u_cmp (
        .valid   (bus.lane_valid[l]),
        .pc      (bus.lane_pc[l]),
        .select  (bus.trig_cfg[t].select),
        .execute (bus.trig_cfg[t].execute),
        .m       (bus.trig_cfg[t].m),
        .match   (bus.trig_cfg[t].match),
        .tdata2  (bus.trig_cfg[t].tdata2),
        .hit     (raw[l][t])
      );
    end
  end

  always_comb begin
    gated    = '0;
    chainer  = '0;
    elig     = '0;
    elig_any = '0;
    arm_src  = '0;
    fire     = '0;
    match_d  = '0;
    for (int unsigned t = 1; t < NUM_TRIG; t++) gated[t] = bus.trig_cfg[t-1].chain;
    // chain on the last trigger has nothing to arm, so it is ignored
    for (int unsigned t = 0; t + 1 < NUM_TRIG; t++) chainer[t] = bus.trig_cfg[t].chain;
    for (int unsigned t = 0; t < NUM_TRIG; t++) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        elig[l][t]  = raw[l][t] & (~gated[t] | armed_q[t]) & ~chainer[t];
        elig_any[t] = elig_any[t] | elig[l][t];
        arm_src[t]  = arm_src[t] | (raw[l][t] & chainer[t]);
      end
      fire[t] = elig_any[t] & fire_ok[t];
      for (int unsigned l = 0; l < NUM_LANES; l++)
        match_d[l][t] = elig[l][t] & fire[t] & ~bus.dec_flush & ~bus.cfg_wr_en[t];
    end
    // Fire consumes the arm, a same-cycle arm wins, then flush/CSR writes
    // override everything.
    for (int unsigned t = 0; t < NUM_TRIG; t++)
      armed_d[t] = armed_q[t] & ~(fire[t] & gated[t]);
    for (int unsigned t = 1; t < NUM_TRIG; t++)
      armed_d[t] = armed_d[t] | arm_src[t-1];
    for (int unsigned t = 0; t < NUM_TRIG; t++)
      if (bus.dec_flush || bus.cfg_wr_en[t]) armed_d[t] = 1'b0;
    for (int unsigned t = 1; t < NUM_TRIG; t++)
      if (bus.cfg_wr_en[t-1]) armed_d[t] = 1'b0;
  end

`ifdef RV_TRIGGER_HITCNT_EN
  localparam int unsigned CMP_W = ((CNT_W > TRIG_CNT_W) ? CNT_W : TRIG_CNT_W) + 1;
  logic [NUM_TRIG-1:0][CNT_W-1:0] cnt_q;

  always_comb begin
    fire_ok = '0;
    for (int unsigned t = 0; t < NUM_TRIG; t++)
      fire_ok[t] = (bus.trig_cfg[t].hit_lim == '0) ||
                   ((CMP_W'(cnt_q[t]) + CMP_W'(1)) >= CMP_W'(bus.trig_cfg[t].hit_lim));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned t = 0; t < NUM_TRIG; t++) begin
        if (bus.cfg_wr_en[t])
          cnt_q[t] <= '0;
        else if (!bus.dec_flush && elig_any[t] && (cnt_q[t] != '1))
          cnt_q[t] <= cnt_q[t] + CNT_W'(1);
      end
    end
  end
`else
  logic unused_hit_lim;
  assign fire_ok = '1;
  always_comb begin
    unused_hit_lim = 1'b0;
    for (int unsigned t = 0; t < NUM_TRIG; t++)
      unused_hit_lim = unused_hit_lim ^ (^bus.trig_cfg[t].hit_lim);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= '0;
      match_q <= '0;
    end else begin
      armed_q <= armed_d;
      match_q <= match_d;
    end
  end

  assign bus.lane_trigger_match = match_q;
  assign bus.trig_armed         = armed_q;

endmodule

// File: tb/tb_dec_trigger_seq.sv
module tb_dec_trigger_seq;
  import swerv_types_pkg::*;

  localparam int unsigned NT = 4;
  localparam int unsigned NL = 2;
`ifdef RV_TRIGGER_HITCNT_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_trigger_seq_if #(.NUM_TRIG(NT), .NUM_LANES(NL)) bus ();

  dec_trigger_seq #(.NUM_TRIG(NT), .NUM_LANES(NL), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string          tag;
    logic [NL*NT-1:0] m;
    logic [NT-1:0]  a;
  } exp_t;

  exp_t sb[$];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Push the expected response for the inputs now on the bus, clock once,
  // then pop and compare the registered outputs.
  task automatic step(input string tag, input logic [NL*NT-1:0] em, input logic [NT-1:0] ea);
    exp_t e;
    e.tag = tag; e.m = em; e.a = ea;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_match"}, 64'(bus.lane_trigger_match), 64'(e.m));
    check({e.tag, "_armed"}, 64'(bus.trig_armed), 64'(e.a));
    bus.lane_valid = '0;
    bus.cfg_wr_en  = '0;
    bus.dec_flush  = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic set_trig(input int unsigned i, input logic [31:0] td, input logic mt,
                          input logic ch, input logic [7:0] hl);
    trig_cfg_t c;
    c = '0;
    c.execute = 1'b1; c.m = 1'b1; c.match = mt; c.chain = ch;
    c.tdata2 = td; c.hit_lim = hl;
    bus.trig_cfg[i] = c;
  endtask

  task automatic drive(input logic v0, input logic [31:0] p0, input logic v1, input logic [31:0] p1);
    bus.lane_valid = {v1, v0};
    bus.lane_pc[0] = p0[31:1];
    bus.lane_pc[1] = p1[31:1];
  endtask

  task automatic write_cfg();
    bus.cfg_wr_en = '1;
    step("cfg", '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.trig_cfg = '0; bus.cfg_wr_en = '0; bus.lane_valid = '0;
    bus.lane_pc = '0; bus.dec_flush = 1'b0;
    step("reset", '0, '0);

    // exact compare, one-cycle latency
    set_trig(0, 32'h8000_1000, 1'b0, 1'b0, 8'd0);
    write_cfg();
    drive(1, 32'h8000_1000, 1, 32'h8000_2000);
    step("exact_hit", 8'h01, '0);
    step("exact_idle", '0, '0);

    // masked compare, 256-byte window
    set_trig(0, 32'h8000_10FF, 1'b1, 1'b0, 8'd0);
    write_cfg();
    drive(0, 32'h0, 1, 32'h8000_1044);
    step("mask_in", 8'h10, '0);
    drive(0, 32'h0, 1, 32'h8000_1100);
    step("mask_out", '0, '0);
    drive(1, 32'h8000_10FE, 1, 32'h8000_0FFE);
    step("mask_edge", 8'h01, '0);

    // chaining T0 -> T1
    bus.trig_cfg = '0;
    set_trig(0, 32'h100, 1'b0, 1'b1, 8'd0);
    set_trig(1, 32'h200, 1'b0, 1'b0, 8'd0);
    write_cfg();
    drive(1, 32'h100, 0, 32'h0);   step("ch_arm", '0, 4'h2);
    drive(1, 32'h200, 0, 32'h0);   step("ch_fire", 8'h02, '0);
    drive(1, 32'h200, 0, 32'h0);   step("ch_unarmed", '0, '0);
    drive(1, 32'h100, 1, 32'h200); step("ch_same", '0, 4'h2);
    step("ch_hold", '0, 4'h2);
    drive(1, 32'h200, 1, 32'h100); step("ch_armfire", 8'h02, 4'h2);
    drive(1, 32'h200, 0, 32'h0); bus.dec_flush = 1'b1;
    step("ch_flush", '0, '0);
    drive(1, 32'h100, 0, 32'h0);   step("ch_rearm", '0, 4'h2);
    bus.cfg_wr_en = 4'h1;          step("ch_wr0", '0, '0);
    drive(1, 32'h100, 0, 32'h0);   step("ch_rearm2", '0, 4'h2);
    drive(1, 32'h100, 0, 32'h0); bus.cfg_wr_en = 4'h1;
    step("ch_wr0_prio", '0, '0);
    drive(1, 32'h100, 0, 32'h0);   step("ch_rearm3", '0, 4'h2);
    drive(1, 32'h200, 0, 32'h0); bus.cfg_wr_en = 4'h2;
    step("ch_wr1_supp", '0, '0);

    // chain on the last trigger is ignored
    set_trig(3, 32'h300, 1'b0, 1'b1, 8'd0);
    write_cfg();
    drive(1, 32'h300, 0, 32'h0);   step("last_chain", 8'h08, '0);

    // hit limit
    bus.trig_cfg = '0;
    set_trig(0, 32'h400, 1'b0, 1'b0, 8'd3);
    write_cfg();
    for (int c = 1; c <= 4; c++) begin
      drive(1, 32'h400, 1, 32'h400);
      step($sformatf("hl3_c%0d", c), (HC && c < 3) ? 8'h00 : 8'h11, '0);
    end
    write_cfg();
    drive(1, 32'h400, 1, 32'h400); step("hlf_c1", HC ? 8'h00 : 8'h11, '0);
    drive(1, 32'h400, 1, 32'h400); bus.dec_flush = 1'b1;
    step("hlf_flush", '0, '0);
    drive(1, 32'h400, 1, 32'h400); step("hlf_c2", HC ? 8'h00 : 8'h11, '0);
    drive(1, 32'h400, 1, 32'h400); step("hlf_c3", 8'h11, '0);

    set_trig(0, 32'h400, 1'b0, 1'b0, 8'd0);
    write_cfg();
    drive(1, 32'h400, 0, 32'h0);   step("hl0", 8'h01, '0);

    // counter saturation: hit_lim=255 fires from cycle 255 on and keeps firing
    set_trig(0, 32'h400, 1'b0, 1'b0, 8'd255);
    write_cfg();
    for (int c = 1; c <= 260; c++) begin
      drive(1, 32'h400, 0, 32'h0);
      step($sformatf("sat_c%0d", c), (!HC || c >= 255) ? 8'h01 : 8'h00, '0);
    end

    // reset mid-chain with a partially counted trigger
    bus.trig_cfg = '0;
    set_trig(0, 32'h100, 1'b0, 1'b1, 8'd0);
    set_trig(1, 32'h200, 1'b0, 1'b0, 8'd0);
    set_trig(2, 32'h500, 1'b0, 1'b0, 8'd3);
    write_cfg();
    drive(1, 32'h100, 1, 32'h500); step("rs_a", HC ? 8'h00 : 8'h40, 4'h2);
    drive(1, 32'h500, 0, 32'h0);   step("rs_b", HC ? 8'h00 : 8'h04, 4'h2);
    drive(1, 32'h500, 1, 32'h200); rst = 1'b1;
    step("rs_rst", '0, '0);
    drive(1, 32'h500, 1, 32'h200); step("rs_after", HC ? 8'h00 : 8'h04, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
